// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-requester round-robin scheduler for the shared 8-bit ALU
//
// Purpose:
//    Arbitrates between two requesters and latches the winner's operands and opcode.
//    It drives them from registers onto the combinational ALU for SETTLE_CYCLES
//    cycles, samples alu_r, and returns the result as a one-cycle response pulse
//    on the granted requester's port.
//
// Parameters:
//    SETTLE_CYCLES  cycles the ALU inputs are held before alu_r is sampled (1..15)
//
// Optional feature:
//    ALU_SCHED_DIVZERO_EN  when defined, a quotient or remainder with b==0 bypasses
//                          the ALU and responds with resp_r=8'hFF, resp_err=1
//
// Ports:
//    clk, rst                       clock, synchronous active-high reset
//    req0_* / req1_*                request channels (valid/ready, a, b, op, cin)
//    resp0_valid / resp1_valid      one-cycle response pulse per requester
//    resp_r, resp_err               shared result and error flag
//    alu_a, alu_b, alu_op, alu_cin  registered ALU operands
//    alu_r                          ALU result
//    busy                           high whenever the scheduler is not idle

module alu_sched #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [2:0] req0_op,
   input  logic       req0_cin,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic [2:0] req1_op,
   input  logic       req1_cin,
   output logic       resp0_valid,
   output logic       resp1_valid,
   output logic [7:0] resp_r,
   output logic       resp_err,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_op,
   output logic       alu_cin,
   input  logic [7:0] alu_r,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

   state_t     state;
   logic       last_grant;
   logic       grant_id;
   logic [3:0] settle_cnt;

   logic       win0;
   logic       win1;
   logic       handshake;
   logic [7:0] cap_a;
   logic [7:0] cap_b;
   logic [2:0] cap_op;
   logic       cap_cin;
   logic       op_illegal;
   logic       op_divzero;

   // A lone requester always wins; under contention the one not served last wins.
   assign win0 = req0_valid & (~req1_valid | last_grant);
   assign win1 = req1_valid & (~req0_valid | ~last_grant);

   assign req0_ready = (state == IDLE) & win0;
   assign req1_ready = (state == IDLE) & win1;
   assign handshake  = (state == IDLE) & (win0 | win1);

   // Payload of the winner; only meaningful when handshake is high.
   assign cap_a   = win1 ? req1_a   : req0_a;
   assign cap_b   = win1 ? req1_b   : req0_b;
   assign cap_op  = win1 ? req1_op  : req0_op;
   assign cap_cin = win1 ? req1_cin : req0_cin;

   assign op_illegal = (cap_op[2:1] == 2'b11);

`ifdef ALU_SCHED_DIVZERO_EN
   assign op_divzero = ((cap_op == 3'd4) | (cap_op == 3'd5)) & (cap_b == 8'h00);
`else
   assign op_divzero = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         grant_id    <= 1'b0;
         settle_cnt  <= 4'd0;
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
         resp_r      <= 8'h00;
         resp_err    <= 1'b0;
         alu_a       <= 8'h00;
         alu_b       <= 8'h00;
         alu_op      <= 3'd0;
         alu_cin     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         // Response pulses last exactly the one RESP cycle.
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (handshake) begin
                  grant_id   <= win1;
                  last_grant <= win1;
                  busy       <= 1'b1;
                  if (op_illegal || op_divzero) begin
                     // Bypass the ALU entirely; its outputs keep their last values.
                     resp_r      <= op_illegal ? 8'h00 : 8'hFF;
                     resp_err    <= 1'b1;
                     resp0_valid <= ~win1;
                     resp1_valid <= win1;
                     state       <= RESP;
                  end else begin
                     alu_a      <= cap_a;
                     alu_b      <= cap_b;
                     alu_op     <= cap_op;
                     alu_cin    <= cap_cin;
                     settle_cnt <= SETTLE_LD;
                     state      <= EXEC;
                  end
               end
            end

            EXEC: begin
               // The <= guard keeps an out-of-range load of 0 from wrapping forever.
               if (settle_cnt <= 4'd1) begin
                  resp_r      <= alu_r;
                  resp_err    <= 1'b0;
                  resp0_valid <= ~grant_id;
                  resp1_valid <= grant_id;
                  state       <= RESP;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end

            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - directed self-checking bench for alu_sched

module tb_alu_sched;

   logic       clk;
   logic       rst;
   logic       v       [2][2];
   logic       rdy     [2][2];
   logic       rv      [2][2];
   logic [7:0] a       [2][2];
   logic [7:0] b       [2][2];
   logic [2:0] op      [2][2];
   logic       cin     [2][2];
   logic [7:0] resp_r  [2];
   logic       resp_err[2];
   logic [7:0] alu_a   [2];
   logic [7:0] alu_b   [2];
   logic [2:0] alu_op  [2];
   logic       alu_cin [2];
   logic [7:0] alu_r   [2];
   logic       busy    [2];

   int chk_total = 0;
   int chk_pass  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU; shifts use b[2:0] as the amount, divide by zero gives 8'hFF.
   function automatic logic [7:0] alu_f(input logic [7:0] fa, input logic [7:0] fb,
                                        input logic [2:0] fop, input logic fcin);
      case (fop)
         3'd0: alu_f = fa + fb + {7'd0, fcin};
         3'd1: alu_f = fa - fb;
         3'd2: alu_f = fa >> fb[2:0];
         3'd3: alu_f = fa << fb[2:0];
         3'd4: alu_f = (fb == 8'h00) ? 8'hFF : fa / fb;
         3'd5: alu_f = (fb == 8'h00) ? 8'hFF : fa % fb;
         default: alu_f = 8'h00;
      endcase
   endfunction

   assign alu_r[0] = alu_f(alu_a[0], alu_b[0], alu_op[0], alu_cin[0]);
   assign alu_r[1] = alu_f(alu_a[1], alu_b[1], alu_op[1], alu_cin[1]);

   alu_sched #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(v[0][0]), .req0_ready(rdy[0][0]), .req0_a(a[0][0]), .req0_b(b[0][0]),
      .req0_op(op[0][0]), .req0_cin(cin[0][0]),
      .req1_valid(v[0][1]), .req1_ready(rdy[0][1]), .req1_a(a[0][1]), .req1_b(b[0][1]),
      .req1_op(op[0][1]), .req1_cin(cin[0][1]),
      .resp0_valid(rv[0][0]), .resp1_valid(rv[0][1]),
      .resp_r(resp_r[0]), .resp_err(resp_err[0]),
      .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]), .alu_cin(alu_cin[0]),
      .alu_r(alu_r[0]), .busy(busy[0])
   );

   alu_sched #(.SETTLE_CYCLES(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .req0_valid(v[1][0]), .req0_ready(rdy[1][0]), .req0_a(a[1][0]), .req0_b(b[1][0]),
      .req0_op(op[1][0]), .req0_cin(cin[1][0]),
      .req1_valid(v[1][1]), .req1_ready(rdy[1][1]), .req1_a(a[1][1]), .req1_b(b[1][1]),
      .req1_op(op[1][1]), .req1_cin(cin[1][1]),
      .resp0_valid(rv[1][0]), .resp1_valid(rv[1][1]),
      .resp_r(resp_r[1]), .resp_err(resp_err[1]),
      .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]), .alu_cin(alu_cin[1]),
      .alu_r(alu_r[1]), .busy(busy[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_total++;
      if (obs === exp) chk_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request on instance d, port p; latency counts edges from the handshake edge
   // to the first cycle in which the response pulse is visible.
   task automatic do_req(input int d, input int p, input logic [7:0] ta, input logic [7:0] tb,
                         input logic [2:0] top, input logic tcin, input int exp_lat,
                         input logic [7:0] exp_r, input logic exp_err, input string tag);
      int n;
      int lat;
      a[d][p] = ta; b[d][p] = tb; op[d][p] = top; cin[d][p] = tcin;
      v[d][p] = 1'b1;
      #1;
      n = 0;
      while (!rdy[d][p] && n < 50) begin
         tick();
         #1;
         n++;
      end
      check({tag, "_ready"}, rdy[d][p], 1'b1);
      tick();
      v[d][p] = 1'b0;
      lat = 1;
      while (!rv[d][p] && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_resp_r"}, resp_r[d], exp_r);
      check({tag, "_resp_err"}, resp_err[d], exp_err);
      check({tag, "_other_port"}, rv[d][1-p], 1'b0);
      tick();
      check({tag, "_pulse_width"}, rv[d][p], 1'b0);
      check({tag, "_busy_after"}, busy[d], 1'b0);
   endtask

   int exp_order[6];
   int g;
   int r;
   int c0;
   int c1;
   int gid;

   initial begin
      exp_order = '{0, 1, 0, 1, 0, 1};
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            v[d][p] = 1'b0; a[d][p] = 8'h00; b[d][p] = 8'h00; op[d][p] = 3'd0; cin[d][p] = 1'b0;
         end
      end
      tick(); tick(); tick();
      rst = 1'b0;
      #1;

      // Reset state
      check("rst_ready0", rdy[0][0], 1'b0);
      check("rst_ready1", rdy[0][1], 1'b0);
      check("rst_resp_valid", {rv[0][1], rv[0][0]}, 2'b00);
      check("rst_resp_r", resp_r[0], 8'h00);
      check("rst_resp_err", resp_err[0], 1'b0);
      check("rst_alu", {alu_a[0], alu_b[0], alu_op[0], alu_cin[0]}, 20'h0);
      check("rst_busy", busy[0], 1'b0);

      // Contention from reset: 3 requests each, grants must alternate starting with req0
      a[0][0] = 8'h01; b[0][0] = 8'h02; op[0][0] = 3'd0; cin[0][0] = 1'b0;
      a[0][1] = 8'h10; b[0][1] = 8'h20; op[0][1] = 3'd0; cin[0][1] = 1'b0;
      v[0][0] = 1'b1; v[0][1] = 1'b1;
      g = 0; r = 0; c0 = 0; c1 = 0;
      for (int cyc = 0; cyc < 100 && r < 6; cyc++) begin
         #1;
         if (rv[0][0] || rv[0][1]) begin
            if (r < 6) begin
               check("arb_resp_port", {rv[0][1], rv[0][0]}, (exp_order[r] == 1) ? 2'b10 : 2'b01);
               check("arb_resp_r", resp_r[0], (exp_order[r] == 1) ? 8'h30 : 8'h03);
            end
            r++;
         end
         if ((v[0][0] && rdy[0][0]) || (v[0][1] && rdy[0][1])) begin
            check("arb_single_ready", rdy[0][0] && rdy[0][1], 1'b0);
            gid = rdy[0][1] ? 1 : 0;
            if (g < 6) check("arb_grant", gid, exp_order[g]);
            g++;
            if (gid == 0) c0++;
            else c1++;
         end
         tick();
         if (c0 == 3) v[0][0] = 1'b0;
         if (c1 == 3) v[0][1] = 1'b0;
      end
      check("arb_grant_count", g, 6);
      check("arb_resp_count", r, 6);
      tick();

      // Add with carry
      do_req(0, 0, 8'h0F, 8'h01, 3'd0, 1'b1, 2, 8'h11, 1'b0, "add");

      // Illegal opcode: immediate error, ALU outputs keep the add's operands
      do_req(0, 1, 8'h55, 8'h66, 3'd7, 1'b0, 1, 8'h00, 1'b1, "illegal");
      check("illegal_alu_held", {alu_a[0], alu_b[0], alu_op[0], alu_cin[0]}, {8'h0F, 8'h01, 3'd0, 1'b1});

      // Quotient by zero
`ifdef ALU_SCHED_DIVZERO_EN
      do_req(0, 0, 8'h20, 8'h00, 3'd4, 1'b0, 1, 8'hFF, 1'b1, "divzero");
      check("divzero_alu_held", {alu_a[0], alu_b[0], alu_op[0]}, {8'h0F, 8'h01, 3'd0});
`else
      do_req(0, 0, 8'h20, 8'h00, 3'd4, 1'b0, 2, 8'hFF, 1'b0, "divzero");
`endif

      // Subtract with borrow wrap
      do_req(0, 1, 8'h05, 8'h07, 3'd1, 1'b0, 2, 8'hFE, 1'b0, "sub");

      // Reset in the EXEC cycle aborts; last_grant returns to 1
      a[0][0] = 8'h03; b[0][0] = 8'h04; op[0][0] = 3'd0; cin[0][0] = 1'b0;
      v[0][0] = 1'b1;
      #1;
      check("abort_ready", rdy[0][0], 1'b1);
      tick();
      v[0][0] = 1'b0;
      check("abort_busy_exec", busy[0], 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("abort_no_resp", {rv[0][1], rv[0][0]}, 2'b00);
      check("abort_alu_ab", {alu_a[0], alu_b[0]}, 16'h0000);
      check("abort_busy", busy[0], 1'b0);
      tick();
      check("abort_no_resp_late", {rv[0][1], rv[0][0]}, 2'b00);
      a[0][1] = 8'h01; b[0][1] = 8'h01; op[0][1] = 3'd0;
      v[0][0] = 1'b1; v[0][1] = 1'b1;
      #1;
      check("abort_regrant", {rdy[0][1], rdy[0][0]}, 2'b01);
      tick();
      v[0][0] = 1'b0; v[0][1] = 1'b0;
      for (int i = 0; i < 10 && busy[0]; i++) tick();
      check("abort_regrant_done", busy[0], 1'b0);

      // SETTLE_CYCLES=4 remainder: ALU inputs held for 4 cycles, response in cycle k+5
      a[1][0] = 8'h64; b[1][0] = 8'h07; op[1][0] = 3'd5; cin[1][0] = 1'b0;
      v[1][0] = 1'b1;
      #1;
      check("s4_ready", rdy[1][0], 1'b1);
      tick();
      v[1][0] = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         check("s4_alu_stable", {alu_a[1], alu_b[1], alu_op[1]}, {8'h64, 8'h07, 3'd5});
         check("s4_no_early_resp", rv[1][0], 1'b0);
         tick();
      end
      check("s4_resp_valid", rv[1][0], 1'b1);
      check("s4_resp_r", resp_r[1], 8'h02);
      check("s4_resp_err", resp_err[1], 1'b0);
      tick();
      check("s4_pulse_width", rv[1][0], 1'b0);
      check("s4_busy_after", busy[1], 1'b0);

      $display("%0d/%0d checks passed", chk_pass, chk_total);
      $finish;
   end

endmodule
